// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//
// Multiplexed seven-segment display driver. NUM_DIGITS hex digits share one
// segment bus. Each digit gets a slot of 2^SCAN_LOG2 clocks, and its enable is
// asserted in that slot only. The driver also provides:
//   - per-digit decimal points
//   - leading-zero blanking
//   - per-digit blink
//   - 16-level brightness, made by PWM inside each slot
//   - a frame snapshot of the inputs, so a digit never tears mid-frame
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   data        hex nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   dp          decimal point request per digit
//   blink_mask  digits that blink
//   blank_lz    enable leading-zero suppression
//   brightness  0 = dimmest (1/16 of a slot), 15 = lit for the whole slot
//   seg_en      one-hot digit enable (registered, polarity per EN_ACTIVE_LOW)
//   seg_data    [6:0] segments g..a, [7] dp (registered, per SEG_ACTIVE_LOW)
//   frame_tick  one-clock pulse when the scan returns to digit 0
//
// Handshake: none. Inputs are sampled level-sensitively. data/dp/blink_mask/
// blank_lz are captured once per frame. brightness is used live.
// -----------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_LOG2      = 14,
    parameter int BLINK_DIV      = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit EN_ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   seg_en,
    output logic [7:0]              seg_data,
    output logic                    frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BLK_W = $clog2(BLINK_DIV);

    localparam logic [SCAN_LOG2-1:0] SLOT_MAX = '1;
    localparam logic [IDX_W-1:0]     IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]     BLK_MAX  = BLK_W'(BLINK_DIV - 1);

    // Scan state
    logic [SCAN_LOG2-1:0]    slot_cnt;
    logic [IDX_W-1:0]        digit_idx;

    // Frame snapshot. Every display decision reads these registers.
    logic [4*NUM_DIGITS-1:0] snap_data;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blink;
    logic                    snap_blank_lz;

    // Blink timebase
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_phase;

    // Output registers, stored in active-high form
    logic [NUM_DIGITS-1:0]   en_q;
    logic [7:0]              seg_q;
    logic                    frame_tick_q;

    // Combinational next-output values
    logic                    slot_wrap;
    logic                    frame_wrap;
    logic [3:0]              pwm_phase;
    logic                    lit;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_blank;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [7:0]              pattern;
    logic [NUM_DIGITS-1:0]   en_next;
    logic [7:0]              seg_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_wrap  = (slot_cnt == SLOT_MAX);
    assign frame_wrap = slot_wrap && (digit_idx == IDX_MAX);

    // The top four bits of the slot counter divide the slot into 16 PWM steps.
    assign pwm_phase = slot_cnt[SCAN_LOG2-1 -: 4];
    assign lit       = (pwm_phase <= brightness);

    // Select the current digit from the snapshot. The loop also builds the
    // leading-zero condition. It walks from the most significant digit down,
    // so zero_run is true at digit i only when nibbles i..NUM_DIGITS-1 are
    // all zero.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_blank = 1'b0;
        onehot    = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap_data[4*i +: 4] == 4'h0);
            if (digit_idx == IDX_W'(i)) begin
                cur_nib   = snap_data[4*i +: 4];
                cur_dp    = snap_dp[i];
                cur_blink = snap_blink[i];
                cur_blank = snap_blank_lz && zero_run && (i != 0);
                onehot[i] = 1'b1;
            end
        end
    end

    // A blanked digit still shows its dp. Blink forces everything off,
    // including dp. A digit outside its PWM on-time is dark.
    always_comb begin
        pattern = {cur_dp, (cur_blank ? 7'h00 : hex_to_seg(cur_nib))};
        if (blink_phase && cur_blink) begin
            pattern = 8'h00;
        end
        seg_next = lit ? pattern : 8'h00;
        en_next  = lit ? onehot : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt      <= '0;
            digit_idx     <= '0;
            snap_data     <= '0;
            snap_dp       <= '0;
            snap_blink    <= '0;
            snap_blank_lz <= 1'b0;
            blink_cnt     <= '0;
            blink_phase   <= 1'b0;
            en_q          <= '0;
            seg_q         <= 8'h00;
            frame_tick_q  <= 1'b0;
        end else begin
            slot_cnt <= slot_cnt + SCAN_LOG2'(1);

            if (slot_wrap) begin
                digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);
            end

            // Capture the inputs on the same edge that returns the scan to
            // digit 0, so that the whole next frame uses one consistent value.
            if (frame_wrap) begin
                snap_data     <= data;
                snap_dp       <= dp;
                snap_blink    <= blink_mask;
                snap_blank_lz <= blank_lz;
            end
            frame_tick_q <= frame_wrap;

            if (blink_cnt == BLK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end

            en_q  <= en_next;
            seg_q <= seg_next;
        end
    end

    // Polarity is applied after the registers. The reset value is therefore
    // always the inactive level at the pins.
    assign seg_en     = EN_ACTIVE_LOW  ? ~en_q  : en_q;
    assign seg_data   = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//
// Directed bench for seven_seg_scan, using NUM_DIGITS=4, SCAN_LOG2=4 and
// BLINK_DIV=100.
//
// Two instances share the inputs:
//   - dut     : active-high polarity
//   - dut_inv : active-low seg_data and seg_en
//
// Outputs are sampled on the falling edge. The output taken after rising
// edge k reflects scan state k-1, and a new frame starts on the edge where
// frame_tick rises.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

    localparam int ND = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // Stimulus
    logic [4*ND-1:0] data;
    logic [ND-1:0]   dp;
    logic [ND-1:0]   blink_mask;
    logic            blank_lz;
    logic [3:0]      brightness;

    // Observed outputs
    logic [ND-1:0]   seg_en;
    logic [7:0]      seg_data;
    logic            frame_tick;
    logic [ND-1:0]   seg_en_n;
    logic [7:0]      seg_data_n;
    logic            frame_tick_n;

    // Clocks since reset release; drives the blink reference model
    int cyc;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    seven_seg_scan #(
        .NUM_DIGITS(ND), .SCAN_LOG2(4), .BLINK_DIV(100),
        .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .resetn(resetn), .data(data), .dp(dp),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .brightness(brightness),
        .seg_en(seg_en), .seg_data(seg_data), .frame_tick(frame_tick)
    );

    seven_seg_scan #(
        .NUM_DIGITS(ND), .SCAN_LOG2(4), .BLINK_DIV(100),
        .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
    ) dut_inv (
        .clk(clk), .resetn(resetn), .data(data), .dp(dp),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .brightness(brightness),
        .seg_en(seg_en_n), .seg_data(seg_data_n), .frame_tick(frame_tick_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Leaves the bench at the falling edge where frame_tick is high.
    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        chk("frame_tick_seen", 32'(frame_tick), 32'd1);
    endtask

    // Call at the falling edge that carries frame_tick. Checks the first and
    // last clock of every digit slot (brightness 15). exp = {d3,d2,d1,d0}.
    task automatic check_frame(input logic [31:0] exp);
        logic [7:0] e;
        for (int d = 0; d < ND; d++) exp_q.push_back(exp[8*d +: 8]);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            e = exp_q.pop_front();
            chk("slot_first_en",  32'(seg_en),   32'(1 << d));
            chk("slot_first_seg", 32'(seg_data), 32'(e));
            repeat (15) @(negedge clk);
            chk("slot_last_en",   32'(seg_en),   32'(1 << d));
            chk("slot_last_seg",  32'(seg_data), 32'(e));
            if (d < ND - 1) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s;
        int d;
        logic [7:0] e;

        resetn     = 1'b0;
        data       = 16'h1234;
        dp         = 4'b0000;
        blink_mask = 4'b0000;
        blank_lz   = 1'b0;
        brightness = 4'd15;

        // Reset values, including the inverted-polarity instance
        repeat (3) @(negedge clk);
        chk("rst_en",      32'(seg_en),       32'h0);
        chk("rst_seg",     32'(seg_data),     32'h00);
        chk("rst_tick",    32'(frame_tick),   32'h0);
        chk("rst_en_inv",  32'(seg_en_n),     32'hF);
        chk("rst_seg_inv", 32'(seg_data_n),   32'hFF);
        chk("rst_tick_inv", 32'(frame_tick_n), 32'h0);

        // The first frame shows the cleared snapshot: digit 0 reads "0"
        resetn = 1'b1;
        @(negedge clk);
        chk("first_en",      32'(seg_en),     32'h1);
        chk("first_seg",     32'(seg_data),   32'h3F);
        chk("first_en_inv",  32'(seg_en_n),   32'hE);
        chk("first_seg_inv", 32'(seg_data_n), 32'hC0);

        // Frame period, then 1234 decoded per digit
        sync_frame();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        chk("frame_period", 32'(n), 32'd64);
        check_frame({8'h06, 8'h5B, 8'h4F, 8'h66});

        // Leading-zero blanking on and off
        data     = 16'h0050;
        blank_lz = 1'b1;
        sync_frame();
        check_frame({8'h00, 8'h00, 8'h6D, 8'h3F});
        blank_lz = 1'b0;
        sync_frame();
        check_frame({8'h3F, 8'h3F, 8'h6D, 8'h3F});

        // Brightness 3: lit for PWM steps 0..3 of the slot
        data       = 16'h1234;
        brightness = 4'd3;
        sync_frame();
        sync_frame();
        for (int p = 0; p < 16; p++) begin
            @(negedge clk);
            chk("pwm3_en",  32'(seg_en),   (p <= 3) ? 32'h1  : 32'h0);
            chk("pwm3_seg", 32'(seg_data), (p <= 3) ? 32'h66 : 32'h00);
        end
        brightness = 4'd0;
        sync_frame();
        n = 0;
        for (int p = 0; p < 16; p++) begin
            @(negedge clk);
            if (seg_en != '0) n++;
        end
        chk("pwm0_lit_clocks", 32'(n), 32'd1);

        // dp on digit 2, blink on digit 0, all digits "8".
        // Blink phase after edge k is (k/100)%2.
        brightness = 4'd15;
        data       = 16'h8888;
        dp         = 4'b0100;
        blink_mask = 4'b0001;
        sync_frame();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            s = cyc - 1;
            d = (s / 16) % 4;
            if (d == 2)                         e = 8'hFF;
            else if (d == 0 && (s / 100) % 2 == 1) e = 8'h00;
            else                                e = 8'h7F;
            chk("blink_en",  32'(seg_en),   32'(1 << d));
            chk("blink_seg", 32'(seg_data), 32'(e));
        end

        // A mid-frame data change waits for the next frame
        dp         = 4'b0000;
        blink_mask = 4'b0000;
        data       = 16'h1234;
        sync_frame();
        sync_frame();
        @(negedge clk);
        chk("mid_d0", 32'(seg_data), 32'h66);
        data = 16'hABCD;
        repeat (16) @(negedge clk);
        chk("mid_d1", 32'(seg_data), 32'h4F);
        repeat (16) @(negedge clk);
        chk("mid_d2", 32'(seg_data), 32'h5B);
        repeat (16) @(negedge clk);
        chk("mid_d3", 32'(seg_data), 32'h06);
        sync_frame();
        check_frame({8'h77, 8'h7C, 8'h39, 8'h5E});

        // Asynchronous reset in the middle of a slot
        sync_frame();
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_en",      32'(seg_en),     32'h0);
        chk("async_rst_seg",     32'(seg_data),   32'h00);
        chk("async_rst_tick",    32'(frame_tick), 32'h0);
        chk("async_rst_en_inv",  32'(seg_en_n),   32'hF);
        chk("async_rst_seg_inv", 32'(seg_data_n), 32'hFF);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("restart_en",  32'(seg_en),   32'h1);
        chk("restart_seg", 32'(seg_data), 32'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
